// File: rtl/axi_lite_uart_csr.sv
// AXI4-Lite register front end for the UART. It holds the TX/RX byte FIFOs, CONFIG, a STATUS
// register with sticky error bits, and a maskable registered interrupt.
module axi_lite_uart_csr #(
  parameter int          P_S_AXI_ADDR_WIDTH = 16,
  parameter int          P_FIFO_DEPTH       = 8,
  parameter logic [31:0] P_CFG_RESET        = 32'h8400_0032
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [P_S_AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                          s_axi_awvalid,
  output logic                          s_axi_awready,
  input  logic [31:0]                   s_axi_wdata,
  input  logic [3:0]                    s_axi_wstrb,
  input  logic                          s_axi_wvalid,
  output logic                          s_axi_wready,
  output logic [1:0]                    s_axi_bresp,
  output logic                          s_axi_bvalid,
  input  logic                          s_axi_bready,
  input  logic [P_S_AXI_ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                          s_axi_arvalid,
  output logic                          s_axi_arready,
  output logic [31:0]                   s_axi_rdata,
  output logic [1:0]                    s_axi_rresp,
  output logic                          s_axi_rvalid,
  input  logic                          s_axi_rready,
  output logic [7:0]                    o_tx_data,
  output logic                          o_tx_valid,
  input  logic                          i_tx_ready,
  input  logic [7:0]                    i_rx_data,
  input  logic                          i_rx_valid,
  output logic                          o_rts,
  output logic [31:0]                   o_cfg,
  output logic                          o_irq
);

  localparam int PW = $clog2(P_FIFO_DEPTH);
  localparam int CW = $clog2(P_FIFO_DEPTH + 1);
  localparam int FIFO_RX = 0;
  localparam int FIFO_TX = 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    REG_RXDATA = 3'd0,
    REG_TXDATA = 3'd1,
    REG_CONFIG = 3'd2,
    REG_STATUS = 3'd3,
    REG_IRQ_EN = 3'd4
  } reg_e;

  // Only word offsets 0x00..0x10 exist. Any other address bit above bit 1 decodes as unmapped.
  function automatic logic addr_ok(input logic [P_S_AXI_ADDR_WIDTH-1:0] a);
    return ((a >> 5) == '0) && (a[4:2] <= REG_IRQ_EN);
  endfunction

  // ---------------------------------------------------------------- FIFO storage
  logic [7:0]    fifo_mem [2][P_FIFO_DEPTH];
  logic [PW-1:0] wr_ptr   [2];
  logic [PW-1:0] rd_ptr   [2];
  logic [CW-1:0] fifo_cnt [2];
  logic [7:0]    fifo_din [2];
  logic [1:0]    fifo_push;
  logic [1:0]    fifo_pop;
  logic [1:0]    fifo_empty;
  logic [1:0]    fifo_full;

  for (genvar f = 0; f < 2; f++) begin : g_flags
    assign fifo_empty[f] = (fifo_cnt[f] == '0);
    assign fifo_full[f]  = (fifo_cnt[f] == CW'(P_FIFO_DEPTH));
  end

  // NOTE: the storage array has no reset. Pointers and counts alone define which entries are
  // valid, so the array can map onto plain RAM.
  always_ff @(posedge clock) begin
    for (int f = 0; f < 2; f++)
      if (fifo_push[f]) fifo_mem[f][wr_ptr[f]] <= fifo_din[f];
  end

  // NOTE: sequential state always uses non-blocking assignment, so every register in the
  // same edge sees the pre-edge values of the others.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int f = 0; f < 2; f++) begin
        wr_ptr[f]   <= '0;
        rd_ptr[f]   <= '0;
        fifo_cnt[f] <= '0;
      end
    end else begin
      for (int f = 0; f < 2; f++) begin
        if (fifo_push[f]) wr_ptr[f] <= wr_ptr[f] + PW'(1);
        if (fifo_pop[f])  rd_ptr[f] <= rd_ptr[f] + PW'(1);
        if (fifo_push[f] && !fifo_pop[f])      fifo_cnt[f] <= fifo_cnt[f] + CW'(1);
        else if (!fifo_push[f] && fifo_pop[f]) fifo_cnt[f] <= fifo_cnt[f] - CW'(1);
      end
    end
  end

  logic [7:0] rx_head;
  logic [7:0] rx_count;
  logic [7:0] tx_count;

  assign rx_head    = fifo_mem[FIFO_RX][rd_ptr[FIFO_RX]];
  assign o_tx_data  = fifo_mem[FIFO_TX][rd_ptr[FIFO_TX]];
  assign o_tx_valid = ~fifo_empty[FIFO_TX];
  assign o_rts      = fifo_full[FIFO_RX];
  assign rx_count   = 8'(fifo_cnt[FIFO_RX]);
  assign tx_count   = 8'(fifo_cnt[FIFO_TX]);

  // ---------------------------------------------------------------- write channel
  logic                          ready_en;
  logic                          aw_held;
  logic                          w_held;
  logic [P_S_AXI_ADDR_WIDTH-1:0] aw_addr_q;
  logic [31:0]                   w_data_q;
  logic [3:0]                    w_strb_q;

  logic                          aw_hs;
  logic                          w_hs;
  logic                          wr_commit;
  logic                          wr_ok;
  logic [P_S_AXI_ADDR_WIDTH-1:0] wr_addr;
  logic [31:0]                   wr_data;
  logic [3:0]                    wr_strb;
  logic [2:0]                    wr_word;
  logic [1:0]                    wr_resp;

  // ready_en keeps every ready low during reset and for the first edge after reset is released.
  assign s_axi_awready = ready_en & ~aw_held & ~s_axi_bvalid;
  assign s_axi_wready  = ready_en & ~w_held & ~s_axi_bvalid;
  assign aw_hs         = s_axi_awvalid & s_axi_awready;
  assign w_hs          = s_axi_wvalid & s_axi_wready;

  assign wr_addr   = aw_held ? aw_addr_q : s_axi_awaddr;
  assign wr_data   = w_held ? w_data_q : s_axi_wdata;
  assign wr_strb   = w_held ? w_strb_q : s_axi_wstrb;
  assign wr_word   = wr_addr[4:2];
  assign wr_ok     = addr_ok(wr_addr);
  assign wr_commit = (aw_held | aw_hs) & (w_held | w_hs);

  logic tx_wr;
  logic tx_push;
  logic tx_err_set;
  logic cfg_we;
  logic status_w1c;
  logic irq_en_we;

  assign tx_wr      = wr_commit & wr_ok & (wr_word == REG_TXDATA) & wr_strb[0];
  assign tx_push    = tx_wr & ~fifo_full[FIFO_TX];
  assign tx_err_set = tx_wr & fifo_full[FIFO_TX];
  assign cfg_we     = wr_commit & wr_ok & (wr_word == REG_CONFIG);
  assign status_w1c = wr_commit & wr_ok & (wr_word == REG_STATUS) & wr_strb[0];
  assign irq_en_we  = wr_commit & wr_ok & (wr_word == REG_IRQ_EN) & wr_strb[0];
  assign wr_resp    = !wr_ok ? RESP_DECERR : (tx_err_set ? RESP_SLVERR : RESP_OKAY);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ready_en     <= 1'b0;
      aw_held      <= 1'b0;
      w_held       <= 1'b0;
      aw_addr_q    <= '0;
      w_data_q     <= '0;
      w_strb_q     <= '0;
      s_axi_bvalid <= 1'b0;
      s_axi_bresp  <= RESP_OKAY;
    end else begin
      ready_en <= 1'b1;
      if (s_axi_bvalid && s_axi_bready) s_axi_bvalid <= 1'b0;
      if (wr_commit) begin
        aw_held      <= 1'b0;
        w_held       <= 1'b0;
        s_axi_bvalid <= 1'b1;
        s_axi_bresp  <= wr_resp;
      end else begin
        if (aw_hs) begin
          aw_held   <= 1'b1;
          aw_addr_q <= s_axi_awaddr;
        end
        if (w_hs) begin
          w_held   <= 1'b1;
          w_data_q <= s_axi_wdata;
          w_strb_q <= s_axi_wstrb;
        end
      end
    end
  end

  // ---------------------------------------------------------------- control / status state
  logic [31:0] cfg;
  logic [2:0]  irq_en;
  logic        rx_overrun;
  logic        tx_err;
  logic        rx_push;
  logic        rx_pop;
  logic        rx_overrun_set;
  logic [31:0] status_word;

  assign o_cfg = cfg;

  // A full RX FIFO still takes a byte when a read pops it in the same cycle.
  assign rx_push        = i_rx_valid & (~fifo_full[FIFO_RX] | rx_pop);
  assign rx_overrun_set = i_rx_valid & fifo_full[FIFO_RX] & ~rx_pop;

  assign fifo_push[FIFO_RX] = rx_push;
  assign fifo_pop[FIFO_RX]  = rx_pop;
  assign fifo_din[FIFO_RX]  = i_rx_data;
  assign fifo_push[FIFO_TX] = tx_push;
  assign fifo_pop[FIFO_TX]  = o_tx_valid & i_tx_ready;
  assign fifo_din[FIFO_TX]  = wr_data[7:0];

  assign status_word = {8'b0, tx_count, rx_count, 2'b0, tx_err, rx_overrun,
                        fifo_full[FIFO_TX], fifo_empty[FIFO_TX],
                        fifo_full[FIFO_RX], ~fifo_empty[FIFO_RX]};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cfg        <= P_CFG_RESET;
      irq_en     <= '0;
      rx_overrun <= 1'b0;
      tx_err     <= 1'b0;
      o_irq      <= 1'b0;
    end else begin
      if (cfg_we)
        for (int b = 0; b < 4; b++)
          if (wr_strb[b]) cfg[8*b +: 8] <= wr_data[8*b +: 8];
      if (irq_en_we) irq_en <= wr_data[2:0];
      // A set event in the same cycle as its W1C clear wins.
      rx_overrun <= rx_overrun_set | (rx_overrun & ~(status_w1c & wr_data[4]));
      tx_err     <= tx_err_set | (tx_err & ~(status_w1c & wr_data[5]));
      o_irq      <= |(irq_en & {rx_overrun | tx_err, fifo_empty[FIFO_TX], ~fifo_empty[FIFO_RX]});
    end
  end

  // ---------------------------------------------------------------- read channel
  logic        ar_hs;
  logic        rd_ok;
  logic [2:0]  rd_word;
  logic [31:0] rd_value;

  assign s_axi_arready = ready_en & ~s_axi_rvalid;
  assign ar_hs         = s_axi_arvalid & s_axi_arready;
  assign rd_word       = s_axi_araddr[4:2];
  assign rd_ok         = addr_ok(s_axi_araddr);
  assign rx_pop        = ar_hs & rd_ok & (rd_word == REG_RXDATA) & ~fifo_empty[FIFO_RX];

  // NOTE: every combinational output gets a default first, so no path through the block infers a latch.
  always_comb begin
    rd_value = '0;
    if (rd_ok) begin
      case (rd_word)
        REG_RXDATA: if (!fifo_empty[FIFO_RX]) rd_value = {23'b0, 1'b1, rx_head};
        REG_CONFIG: rd_value = cfg;
        REG_STATUS: rd_value = status_word;
        REG_IRQ_EN: rd_value = {29'b0, irq_en};
        default:    rd_value = '0;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s_axi_rvalid <= 1'b0;
      s_axi_rdata  <= '0;
      s_axi_rresp  <= RESP_OKAY;
    end else if (ar_hs) begin
      s_axi_rvalid <= 1'b1;
      s_axi_rdata  <= rd_value;
      s_axi_rresp  <= rd_ok ? RESP_OKAY : RESP_DECERR;
    end else if (s_axi_rready) begin
      s_axi_rvalid <= 1'b0;
    end
  end

  // Byte-lane address bits carry no meaning for a 32-bit register file.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{wr_addr[1:0], s_axi_araddr[1:0]};

endmodule

// File: tb/tb_axi_lite_uart_csr.sv
// Directed bench for axi_lite_uart_csr. A queue-based register model is checked on every cycle,
// and hand-computed literals pin the model.
module tb_axi_lite_uart_csr;

  localparam int          DEPTH     = 8;
  localparam logic [31:0] CFG_RESET = 32'h8400_0032;

  logic        clock;
  logic        reset;
  logic [15:0] s_axi_awaddr;
  logic        s_axi_awvalid;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wvalid;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready;
  logic [15:0] s_axi_araddr;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        i_tx_ready;
  logic [7:0]  i_rx_data;
  logic        i_rx_valid;
  logic        o_rts;
  logic [31:0] o_cfg;
  logic        o_irq;

  axi_lite_uart_csr #(
    .P_S_AXI_ADDR_WIDTH(16),
    .P_FIFO_DEPTH      (DEPTH),
    .P_CFG_RESET       (CFG_RESET)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .s_axi_awaddr (s_axi_awaddr),
    .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready),
    .s_axi_wdata  (s_axi_wdata),
    .s_axi_wstrb  (s_axi_wstrb),
    .s_axi_wvalid (s_axi_wvalid),
    .s_axi_wready (s_axi_wready),
    .s_axi_bresp  (s_axi_bresp),
    .s_axi_bvalid (s_axi_bvalid),
    .s_axi_bready (s_axi_bready),
    .s_axi_araddr (s_axi_araddr),
    .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready),
    .s_axi_rdata  (s_axi_rdata),
    .s_axi_rresp  (s_axi_rresp),
    .s_axi_rvalid (s_axi_rvalid),
    .s_axi_rready (s_axi_rready),
    .o_tx_data    (o_tx_data),
    .o_tx_valid   (o_tx_valid),
    .i_tx_ready   (i_tx_ready),
    .i_rx_data    (i_rx_data),
    .i_rx_valid   (i_rx_valid),
    .o_rts        (o_rts),
    .o_cfg        (o_cfg),
    .o_irq        (o_irq)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- register model
  byte unsigned m_tx[$];
  byte unsigned m_rx[$];
  logic [31:0]  m_cfg;
  logic         m_ovr;
  logic         m_txerr;
  logic [2:0]   m_irq_en;
  logic         m_irq;

  logic        p_wr = 1'b0;
  logic [15:0] p_wr_addr;
  logic [31:0] p_wr_data;
  logic [3:0]  p_wr_strb;
  logic        p_rd = 1'b0;
  logic [15:0] p_rd_addr;
  logic [1:0]  exp_bresp;
  logic [31:0] exp_rdata;
  logic [1:0]  exp_rresp;

  function automatic bit addr_ok(input logic [15:0] a);
    return (a[15:5] == 11'd0) && (a[4:2] <= 3'd4);
  endfunction

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s        = '0;
    s[0]     = (m_rx.size() != 0);
    s[1]     = (m_rx.size() == DEPTH);
    s[2]     = (m_tx.size() == 0);
    s[3]     = (m_tx.size() == DEPTH);
    s[4]     = m_ovr;
    s[5]     = m_txerr;
    s[15:8]  = 8'(m_rx.size());
    s[23:16] = 8'(m_tx.size());
    return s;
  endfunction

  initial begin : model
    int         tx_n;
    int         rx_n;
    bit         rx_popped;
    bit         ovr_set;
    bit         txerr_set;
    bit         irq_next;
    logic [2:0] word;
    forever begin
      @(posedge clock or negedge reset);
      if (!reset) begin
        m_tx.delete();
        m_rx.delete();
        m_cfg    = CFG_RESET;
        m_ovr    = 1'b0;
        m_txerr  = 1'b0;
        m_irq_en = '0;
        m_irq    = 1'b0;
      end else begin
        tx_n      = m_tx.size();
        rx_n      = m_rx.size();
        irq_next  = (m_irq_en[0] && rx_n != 0) || (m_irq_en[1] && tx_n == 0) ||
                    (m_irq_en[2] && (m_ovr || m_txerr));
        rx_popped = 1'b0;
        ovr_set   = 1'b0;
        txerr_set = 1'b0;
        if (p_rd) begin
          word      = p_rd_addr[4:2];
          exp_rresp = addr_ok(p_rd_addr) ? 2'b00 : 2'b11;
          exp_rdata = '0;
          if (addr_ok(p_rd_addr)) begin
            case (word)
              3'd0: if (rx_n > 0) begin
                exp_rdata = 32'h100 | 32'(m_rx.pop_front());
                rx_popped = 1'b1;
              end
              3'd2: exp_rdata = m_cfg;
              3'd3: exp_rdata = m_status();
              3'd4: exp_rdata = {29'b0, m_irq_en};
              default: exp_rdata = '0;
            endcase
          end
        end
        if (p_wr) begin
          word      = p_wr_addr[4:2];
          exp_bresp = addr_ok(p_wr_addr) ? 2'b00 : 2'b11;
          if (addr_ok(p_wr_addr)) begin
            case (word)
              3'd1: if (p_wr_strb[0]) begin
                if (tx_n == DEPTH) begin
                  exp_bresp = 2'b10;
                  txerr_set = 1'b1;
                end else m_tx.push_back(p_wr_data[7:0]);
              end
              3'd2: for (int b = 0; b < 4; b++)
                      if (p_wr_strb[b]) m_cfg[8*b +: 8] = p_wr_data[8*b +: 8];
              3'd3: if (p_wr_strb[0]) begin
                if (p_wr_data[4]) m_ovr = 1'b0;
                if (p_wr_data[5]) m_txerr = 1'b0;
              end
              3'd4: if (p_wr_strb[0]) m_irq_en = p_wr_data[2:0];
              default: ;
            endcase
          end
        end
        if (i_tx_ready && tx_n > 0) void'(m_tx.pop_front());
        if (i_rx_valid) begin
          if (rx_n < DEPTH || rx_popped) m_rx.push_back(i_rx_data);
          else ovr_set = 1'b1;
        end
        if (ovr_set)   m_ovr   = 1'b1;
        if (txerr_set) m_txerr = 1'b1;
        m_irq = irq_next;
      end
    end
  end

  // Continuous outputs are compared against the model on every falling edge.
  initial begin : compare
    forever begin
      @(negedge clock);
      if (cmp_en) begin
        check("tx_valid", 32'(o_tx_valid), 32'(m_tx.size() > 0));
        if (m_tx.size() > 0) check("tx_data", 32'(o_tx_data), 32'(m_tx[0]));
        check("rts", 32'(o_rts), 32'(m_rx.size() == DEPTH));
        check("cfg", o_cfg, m_cfg);
        check("irq", 32'(o_irq), 32'(m_irq));
      end
    end
  end

  // ---------------------------------------------------------------- bus tasks (start and end at a falling edge)
  // w_lead > 0 presents W that many cycles before AW; w_lead < 0 presents AW first.
  task automatic axi_write(input logic [15:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int w_lead, output logic [1:0] resp);
    bit aw_done;
    bit w_done;
    bit fired;
    bit aw_now;
    bit w_now;
    int cyc;
    aw_done = 1'b0; w_done = 1'b0; fired = 1'b0; cyc = 0; resp = 2'b00;
    s_axi_awaddr = addr;
    s_axi_wdata  = data;
    s_axi_wstrb  = strb;
    while (!fired && cyc < 20) begin
      s_axi_awvalid = !aw_done && (cyc >= w_lead);
      s_axi_wvalid  = !w_done && (cyc >= -w_lead);
      #1;
      aw_now = s_axi_awvalid && s_axi_awready;
      w_now  = s_axi_wvalid && s_axi_wready;
      if ((aw_done || aw_now) && (w_done || w_now)) begin
        p_wr      = 1'b1;
        p_wr_addr = addr;
        p_wr_data = data;
        p_wr_strb = strb;
        fired     = 1'b1;
      end
      aw_done = aw_done | aw_now;
      w_done  = w_done | w_now;
      @(negedge clock);
      p_wr = 1'b0;
      cyc++;
    end
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    check("wr_handshake", 32'(fired), 32'd1);
    if (fired) begin
      check("bvalid_rise", 32'(s_axi_bvalid), 32'd1);
      check("bresp", 32'(s_axi_bresp), 32'(exp_bresp));
      resp = s_axi_bresp;
      s_axi_bready = 1'b1;
      @(negedge clock);
      s_axi_bready = 1'b0;
      check("bvalid_drop", 32'(s_axi_bvalid), 32'd0);
    end
  endtask

  task automatic axi_read(input logic [15:0] addr, output logic [31:0] data, output logic [1:0] resp);
    bit hs;
    int cyc;
    hs = 1'b0; cyc = 0;
    s_axi_araddr  = addr;
    s_axi_arvalid = 1'b1;
    while (!hs && cyc < 20) begin
      #1;
      hs = s_axi_arready;
      if (hs) begin
        check("rvalid_early", 32'(s_axi_rvalid), 32'd0);
        p_rd      = 1'b1;
        p_rd_addr = addr;
      end
      @(negedge clock);
      p_rd = 1'b0;
      cyc++;
    end
    s_axi_arvalid = 1'b0;
    check("ar_handshake", 32'(hs), 32'd1);
    check("rvalid_lat1", 32'(s_axi_rvalid), 32'd1);
    check("rdata", s_axi_rdata, exp_rdata);
    check("rresp", 32'(s_axi_rresp), 32'(exp_rresp));
    data = s_axi_rdata;
    resp = s_axi_rresp;
    s_axi_rready = 1'b1;
    @(negedge clock);
    s_axi_rready = 1'b0;
    check("rvalid_drop", 32'(s_axi_rvalid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- directed sequence
  initial begin
    logic [31:0] rd;
    logic [1:0]  rs;
    logic [1:0]  br;
    s_axi_awaddr = '0; s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0;
    s_axi_wvalid = 1'b0; s_axi_bready = 1'b0; s_axi_araddr = '0; s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b0; i_tx_ready = 1'b0; i_rx_data = '0; i_rx_valid = 1'b0;
    reset = 1'b1;
    #2 reset = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_awready", 32'(s_axi_awready), 32'd0);
    check("rst_wready", 32'(s_axi_wready), 32'd0);
    check("rst_arready", 32'(s_axi_arready), 32'd0);
    check("rst_bvalid", 32'(s_axi_bvalid), 32'd0);
    check("rst_rvalid", 32'(s_axi_rvalid), 32'd0);
    check("rst_rdata", s_axi_rdata, 32'd0);
    check("rst_irq", 32'(o_irq), 32'd0);
    check("rst_cfg", o_cfg, 32'h8400_0032);
    reset  = 1'b1;
    cmp_en = 1'b1;
    @(negedge clock);

    // Reset-state readback
    axi_read(16'h0008, rd, rs);
    check("lit_cfg_read", rd, 32'h8400_0032);
    check("lit_cfg_resp", 32'(rs), 32'd0);
    axi_read(16'h000C, rd, rs);
    check("lit_status_reset", rd, 32'h0000_0004);

    // Two TX bytes held, then drained in order
    axi_write(16'h0004, 32'h41, 4'hF, 0, br);
    axi_write(16'h0004, 32'h42, 4'hF, 0, br);
    axi_read(16'h000C, rd, rs);
    check("lit_status_tx2", rd, 32'h0002_0000);
    check("lit_tx_head41", 32'(o_tx_data), 32'h41);
    i_tx_ready = 1'b1;
    @(negedge clock);
    check("lit_tx_head42", 32'(o_tx_data), 32'h42);
    @(negedge clock);
    i_tx_ready = 1'b0;
    check("lit_tx_drained", 32'(o_tx_valid), 32'd0);

    // TX overflow -> SLVERR and sticky tx_err, then W1C
    for (int i = 0; i < DEPTH; i++) axi_write(16'h0004, 32'(8'h10 + i), 4'hF, 0, br);
    axi_write(16'h0004, 32'h99, 4'hF, 0, br);
    check("lit_tx_full_slverr", 32'(br), 32'd2);
    axi_read(16'h000C, rd, rs);
    check("lit_status_txerr", rd, 32'h0008_0028);
    axi_write(16'h000C, 32'h20, 4'hF, 0, br);
    axi_read(16'h000C, rd, rs);
    check("lit_status_w1c", rd, 32'h0008_0008);
    check("lit_tx_head10", 32'(o_tx_data), 32'h10);
    i_tx_ready = 1'b1;
    repeat (DEPTH) @(negedge clock);
    i_tx_ready = 1'b0;
    axi_write(16'h0004, 32'h77, 4'b1110, 0, br);
    check("lit_nostrb_okay", 32'(br), 32'd0);
    check("lit_nostrb_nopush", 32'(o_tx_valid), 32'd0);

    // RX overrun, then drain
    for (int i = 0; i <= DEPTH; i++) begin
      i_rx_valid = 1'b1;
      i_rx_data  = 8'hA0 + 8'(i);
      @(negedge clock);
    end
    i_rx_valid = 1'b0;
    check("lit_rts", 32'(o_rts), 32'd1);
    axi_read(16'h000C, rd, rs);
    check("lit_status_rxfull", rd, 32'h0000_0817);
    axi_read(16'h0000, rd, rs);
    check("lit_rx_first", rd, 32'h0000_01A0);
    for (int i = 1; i < DEPTH; i++) axi_read(16'h0000, rd, rs);
    check("lit_rx_last", rd, 32'h0000_01A7);
    axi_read(16'h0000, rd, rs);
    check("lit_rx_empty", rd, 32'd0);
    check("lit_rx_empty_resp", 32'(rs), 32'd0);
    axi_write(16'h000C, 32'h10, 4'h1, 0, br);
    axi_read(16'h000C, rd, rs);
    check("lit_status_clean", rd, 32'h0000_0004);

    // Independent AW/W ordering, byte strobes, decode errors
    axi_write(16'h0008, 32'hFFFF_FFFF, 4'b0010, 3, br);
    check("lit_cfg_strb1", o_cfg, 32'h8400_FF32);
    axi_write(16'h000B, 32'h0000_0055, 4'b0001, -2, br);
    check("lit_cfg_strb0", o_cfg, 32'h8400_FF55);
    axi_read(16'h0040, rd, rs);
    check("lit_decerr_rresp", 32'(rs), 32'd3);
    check("lit_decerr_rdata", rd, 32'd0);
    axi_read(16'h0014, rd, rs);
    check("lit_decerr_0x14", 32'(rs), 32'd3);
    axi_write(16'h0040, 32'h1, 4'hF, 0, br);
    check("lit_decerr_bresp", 32'(br), 32'd3);

    // Interrupt on RX non-empty
    axi_write(16'h0010, 32'hFFFF_FFF9, 4'hF, 0, br);
    axi_read(16'h0010, rd, rs);
    check("lit_irq_en_read", rd, 32'd1);
    i_rx_valid = 1'b1;
    i_rx_data  = 8'h5A;
    @(negedge clock);
    i_rx_valid = 1'b0;
    check("lit_irq_lag", 32'(o_irq), 32'd0);
    @(negedge clock);
    check("lit_irq_set", 32'(o_irq), 32'd1);
    axi_read(16'h0000, rd, rs);
    check("lit_irq_rxbyte", rd, 32'h0000_015A);
    check("lit_irq_clear", 32'(o_irq), 32'd0);

    // Reset in the middle of a write: AW held, W never committed
    s_axi_awaddr  = 16'h0004;
    s_axi_wdata   = 32'h33;
    s_axi_wstrb   = 4'hF;
    s_axi_awvalid = 1'b1;
    @(negedge clock);
    s_axi_awvalid = 1'b0;
    reset = 1'b0;
    #1;
    check("midrst_bvalid", 32'(s_axi_bvalid), 32'd0);
    check("midrst_awready", 32'(s_axi_awready), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check("midrst_no_push", 32'(o_tx_valid), 32'd0);
    check("midrst_no_b", 32'(s_axi_bvalid), 32'd0);
    check("midrst_cfg", o_cfg, 32'h8400_0032);
    axi_read(16'h000C, rd, rs);
    check("lit_status_after_rst", rd, 32'h0000_0004);

    @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
